// File: rtl/hack_ctrl_defs.sv
// Shared definitions for the Hack run controller: FSM state encoding,
// instruction counter width, button indices and a saturating increment.
package hack_ctrl_defs;

    // Controller states; the encoding is visible on o_State.
    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BKPT = 2'd3
    } run_state_t;

    localparam int INSTR_COUNT_W = 32;

    // Bit positions of the three buttons in the debouncer bank.
    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;
    localparam int BTN_HALT = 2;
    localparam int NUM_BTNS = 3;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [INSTR_COUNT_W-1:0] sat_inc(input logic [INSTR_COUNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/hack_button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter and a
// one-cycle press pulse on each accepted 0->1 transition.
module hack_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_CLK,
    input  logic i_RESET,
    input  logic i_Btn,
    output logic o_Level,
    output logic o_Press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             level_prev_reg;
    logic             press_reg;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= i_Btn;
            sync2_reg <= sync1_reg;
        end
    end

    // Adopt a new level only after DEBOUNCE_CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= sync2_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered rising-edge detect on the debounced level; releases give nothing.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            level_prev_reg <= 1'b0;
            press_reg      <= 1'b0;
        end else begin
            level_prev_reg <= level_reg;
            press_reg      <= level_reg & ~level_prev_reg;
        end
    end

    assign o_Level = level_reg;
    assign o_Press = press_reg;

endmodule

// File: rtl/hack_run_controller.sv
// Run/halt/step sequencer for the Hack datapath. Emits a registered
// one-cycle clock-enable strobe, supports a PC breakpoint, a slow-run
// divider and a saturating executed-instruction counter.
module hack_run_controller
    import hack_ctrl_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter bit START_RUNNING   = 1'b0
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic                     i_Run_Btn,
    input  logic                     i_Step_Btn,
    input  logic                     i_Halt_Btn,
    input  logic                     i_Slow,
    input  logic                     i_Bkpt_EN,
    input  logic [15:0]              i_Bkpt_Addr,
    input  logic [15:0]              i_PC,
    output logic                     o_CPU_CLK_EN,
    output logic [1:0]               o_State,
    output logic                     o_Halted,
    output logic [INSTR_COUNT_W-1:0] o_Instr_Count
);

    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_level_unused;

    run_state_t               state_reg, state_next;
    logic [DIV_W-1:0]         div_reg, div_next;
    logic                     skip_reg, skip_next;
    logic                     en_reg, en_next;
    logic [INSTR_COUNT_W-1:0] count_reg, count_next;

    logic halt_pulse;
    logic step_pulse;
    logic run_pulse;
    logic tick;
    logic bkpt_hit;

    assign btn_raw = {i_Halt_Btn, i_Step_Btn, i_Run_Btn};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            hack_button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_CLK  (i_CLK),
                .i_RESET(i_RESET),
                .i_Btn  (btn_raw[gi]),
                .o_Level(btn_level_unused[gi]),
                .o_Press(btn_press[gi])
            );
        end
    endgenerate

    // Halt beats Step beats Run when pulses coincide; the losers are dropped.
    assign halt_pulse = btn_press[BTN_HALT];
    assign step_pulse = btn_press[BTN_STEP] & ~btn_press[BTN_HALT];
    assign run_pulse  = btn_press[BTN_RUN] & ~btn_press[BTN_STEP] & ~btn_press[BTN_HALT];

    // Execution opportunity: every cycle, or once per divider period in slow mode.
    assign tick = i_Slow ? (div_reg == DIV_LAST) : 1'b1;

    // The skip flag lets the instruction sitting on the breakpoint run once after a resume.
    assign bkpt_hit = i_Bkpt_EN & ~skip_reg & (i_PC == i_Bkpt_Addr);

    // Next-state, divider, strobe and counter logic; the divider idles at 0 outside RUN.
    always_comb begin
        state_next = state_reg;
        skip_next  = skip_reg;
        en_next    = 1'b0;
        div_next   = '0;
        count_next = en_reg ? sat_inc(count_reg) : count_reg;

        case (state_reg)
            ST_HALT: begin
                if (run_pulse) begin
                    state_next = ST_RUN;
                    skip_next  = 1'b1;
                end else if (step_pulse) begin
                    state_next = ST_STEP;
                end
            end
            ST_RUN: begin
                if (halt_pulse) begin
                    state_next = ST_HALT;
                end else begin
                    if (i_Slow) begin
                        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
                    end
                    if (tick) begin
                        if (bkpt_hit) begin
                            state_next = ST_BKPT;
                        end else begin
                            en_next   = 1'b1;
                            skip_next = 1'b0;
                        end
                    end
                end
            end
            ST_STEP: begin
                // Single step always completes its one strobe, even if Halt arrives now.
                state_next = ST_HALT;
                en_next    = 1'b1;
            end
            ST_BKPT: begin
                if (halt_pulse) begin
                    state_next = ST_HALT;
                end else if (step_pulse) begin
                    state_next = ST_STEP;
                end else if (run_pulse) begin
                    state_next = ST_RUN;
                    skip_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_HALT;
            end
        endcase
    end

    // State and datapath registers; reset also kills any strobe being issued on that edge.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_reg <= START_RUNNING ? ST_RUN : ST_HALT;
            div_reg   <= '0;
            skip_reg  <= 1'b0;
            en_reg    <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            skip_reg  <= skip_next;
            en_reg    <= en_next;
            count_reg <= count_next;
        end
    end

    assign o_CPU_CLK_EN  = en_reg;
    assign o_State       = state_reg;
    assign o_Halted      = (state_reg == ST_HALT) || (state_reg == ST_BKPT);
    assign o_Instr_Count = count_reg;

endmodule

// File: tb/tb_hack_run_controller.sv
// Directed/randomised bench for hack_run_controller with DEBOUNCE_CYCLES=4,
// RUN_DIV=3. Expected strobe edges are derived from button timing rules.
`timescale 1ns/1ps
module tb_hack_run_controller;

    localparam int DEB    = 4;
    localparam int DIV    = 3;
    // Raw level set before edge c+1 -> the FSM acts on edge c+LAT:
    // two synchronizer flops, DEB stable samples, the press register, the FSM edge.
    localparam int LAT    = DEB + 4;
    localparam int SETTLE = DEB + 8;

    localparam int S_HALT = 0;
    localparam int S_RUN  = 1;
    localparam int S_BKPT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_btn, step_btn, halt_btn, slow, bkpt_en;
    logic [15:0] bkpt_addr, pc;
    logic        en;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] icount;

    hack_run_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .RUN_DIV        (DIV),
        .START_RUNNING  (1'b0)
    ) dut (
        .i_CLK        (clk),
        .i_RESET      (rst),
        .i_Run_Btn    (run_btn),
        .i_Step_Btn   (step_btn),
        .i_Halt_Btn   (halt_btn),
        .i_Slow       (slow),
        .i_Bkpt_EN    (bkpt_en),
        .i_Bkpt_Addr  (bkpt_addr),
        .i_PC         (pc),
        .o_CPU_CLK_EN (en),
        .o_State      (state),
        .o_Halted     (halted),
        .o_Instr_Count(icount)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_total = 0;
    int strobe_q[$];
    int exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: log the edge number of any strobe and advance the bench CPU's PC.
    task automatic next();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (en === 1'b1) begin
            strobe_q.push_back(cyc);
            pc = pc + 16'd1;
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) next();
    endtask

    task automatic drive(input logic r, input logic s, input logic h, input int hold);
        run_btn  = r;
        step_btn = s;
        halt_btn = h;
        wait_n(hold);
        run_btn  = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
    endtask

    function automatic int first_strobe();
        return (strobe_q.size() > 0) ? strobe_q[0] : -1;
    endfunction

    function automatic int last_strobe();
        return (strobe_q.size() > 0) ? strobe_q[strobe_q.size()-1] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c_r, c_h, c_s, gap, n, a, addr2, r_edge;

        rst = 1'b1; run_btn = 0; step_btn = 0; halt_btn = 0;
        slow = 0; bkpt_en = 0; bkpt_addr = 16'd0; pc = 16'd0;
        wait_n(3);
        rst = 1'b0;
        check("reset_state", state, S_HALT);
        check("reset_halted", halted, 1);
        check("reset_icount", icount, 0);
        strobe_q.delete();

        // Idle: no buttons, nothing may happen.
        wait_n(100);
        check("idle_strobes", strobe_q.size(), 0);
        check("idle_state", state, S_HALT);
        check("idle_halted", halted, 1);
        check("idle_icount", icount, 0);

        // Fast run: every cycle from entry until the halt press takes effect.
        for (int it = 0; it < 2; it++) begin
            strobe_q.delete();
            c_r = cyc;
            run_btn = 1'b1;
            wait_n(LAT - 1);
            check("run_before_latency", state, S_HALT);
            next();
            check("run_entered", state, S_RUN);
            check("run_not_halted", halted, 0);
            wait_n(20 - LAT);
            run_btn = 1'b0;
            gap = $urandom_range(0, 15);
            wait_n(gap);
            c_h = cyc;
            drive(0, 0, 1, 10);
            wait_n(SETTLE);
            n = c_h - c_r - 1;
            check("fast_strobe_count", strobe_q.size(), n);
            check("fast_first_edge", first_strobe(), c_r + LAT + 1);
            check("fast_last_edge", last_strobe(), c_h + LAT - 1);
            exp_total += n;
            check("fast_icount", icount, exp_total);
            check("fast_halt_state", state, S_HALT);
        end

        // Slow run: one strobe per DIV cycles, halted at an arbitrary divider phase.
        slow = 1'b1;
        for (int it = 0; it < 3; it++) begin
            strobe_q.delete();
            exp_q.delete();
            c_r = cyc;
            drive(1, 0, 0, 10);
            gap = $urandom_range(5, 25);
            wait_n(gap);
            c_h = cyc;
            drive(0, 0, 1, 10);
            wait_n(SETTLE);
            for (int t = c_r + LAT + DIV; t < c_h + LAT; t += DIV) exp_q.push_back(t);
            check("slow_strobe_count", strobe_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < strobe_q.size(); k++)
                check("slow_strobe_edge", strobe_q[k], exp_q[k]);
            exp_total += exp_q.size();
            check("slow_icount", icount, exp_total);
            check("slow_halt_state", state, S_HALT);
        end
        slow = 1'b0;

        // Breakpoint: PC 0..A-1 execute, then stop at A with no strobe.
        pc = 16'd0;
        a = $urandom_range(2, 9);
        bkpt_addr = 16'(a);
        bkpt_en = 1'b1;
        strobe_q.delete();
        c_r = cyc;
        drive(1, 0, 0, 10);
        wait_n(c_r + LAT + 1 + a - cyc);
        check("bkpt_state", state, S_BKPT);
        check("bkpt_halted", halted, 1);
        check("bkpt_pc", pc, a);
        check("bkpt_strobes", strobe_q.size(), a);
        wait_n(10);
        check("bkpt_holds", strobe_q.size(), a);
        exp_total += a;
        check("bkpt_icount", icount, exp_total);

        // Resume: the breakpoint instruction executes once, then the run continues.
        strobe_q.delete();
        c_r = cyc;
        drive(1, 0, 0, 10);
        gap = $urandom_range(3, 12);
        wait_n(gap);
        c_h = cyc;
        drive(0, 0, 1, 10);
        wait_n(SETTLE);
        n = c_h - c_r - 1;
        check("resume_strobes", strobe_q.size(), n);
        check("resume_first_edge", first_strobe(), c_r + LAT + 1);
        check("resume_pc", pc, a + n);
        check("resume_state", state, S_HALT);
        exp_total += n;

        // Re-arm two instructions ahead, then single-step out of BKPT.
        addr2 = int'(pc) + 2;
        bkpt_addr = 16'(addr2);
        strobe_q.delete();
        drive(1, 0, 0, 10);
        wait_n(SETTLE);
        check("bkpt2_strobes", strobe_q.size(), 2);
        check("bkpt2_state", state, S_BKPT);
        check("bkpt2_pc", pc, addr2);
        exp_total += 2;
        strobe_q.delete();
        c_s = cyc;
        drive(0, 1, 0, 10);
        wait_n(SETTLE);
        check("bkpt_step_strobes", strobe_q.size(), 1);
        check("bkpt_step_edge", first_strobe(), c_s + LAT + 1);
        check("bkpt_step_state", state, S_HALT);
        check("bkpt_step_pc", pc, addr2 + 1);
        exp_total += 1;
        check("bkpt_step_icount", icount, exp_total);
        bkpt_en = 1'b0;

        // Step and Run together from HALT: Step wins, one strobe.
        strobe_q.delete();
        c_s = cyc;
        drive(1, 1, 0, 10);
        wait_n(SETTLE);
        check("step_run_strobes", strobe_q.size(), 1);
        check("step_run_edge", first_strobe(), c_s + LAT + 1);
        check("step_run_state", state, S_HALT);
        exp_total += 1;

        // Halt and Step together: Halt wins, nothing executes.
        strobe_q.delete();
        drive(0, 1, 1, 10);
        wait_n(SETTLE);
        check("halt_step_strobes", strobe_q.size(), 0);
        check("halt_step_state", state, S_HALT);

        // Bouncing Step for 20 cycles, then held: exactly one strobe.
        strobe_q.delete();
        c_s = cyc;
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 2) % 2 == 0);
            next();
        end
        step_btn = 1'b1;
        wait_n(10);
        step_btn = 1'b0;
        wait_n(SETTLE);
        check("bounce_strobes", strobe_q.size(), 1);
        check("bounce_edge", first_strobe(), c_s + 20 + LAT + 1);
        exp_total += 1;
        check("bounce_icount", icount, exp_total);

        // Reset while running: back to HALT, counter cleared, no strobe on the reset edge.
        strobe_q.delete();
        c_r = cyc;
        drive(1, 0, 0, 10);
        wait_n(5);
        check("prereset_strobes", strobe_q.size(), cyc - (c_r + LAT));
        rst = 1'b1;
        next();
        r_edge = cyc;
        rst = 1'b0;
        check("reset_kill_en", en, 0);
        check("reset_kill_last", last_strobe(), r_edge - 1);
        check("reset_run_state", state, S_HALT);
        check("reset_run_icount", icount, 0);
        strobe_q.delete();
        wait_n(30);
        check("postreset_strobes", strobe_q.size(), 0);
        check("postreset_state", state, S_HALT);
        check("postreset_icount", icount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
